// File: rtl/uart_tx_parity_even.sv
// rtl/uart_tx_parity_even.sv - even-parity UART-style serial transmitter with break generation
module uart_tx_parity_even #(
  parameter int DATA_BITS = 4,
  parameter int MIN_IDLE  = 1,
  parameter int BREAK_LEN = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 parity_inject,
  output logic                 in_ready,
  input  logic                 break_req,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_GAP    = 3'd5;
  localparam logic [2:0] ST_BREAK  = 3'd6;

  // One counter serves data bits, gap cycles and break cycles
  localparam int CMAX0 = (BREAK_LEN > DATA_BITS) ? BREAK_LEN : DATA_BITS;
  localparam int CMAX  = (CMAX0 > MIN_IDLE) ? CMAX0 : MIN_IDLE;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] DATA_LOAD      = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] BREAK_LOAD     = CW'(BREAK_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD       = CW'((MIN_IDLE > 0) ? MIN_IDLE - 1 : 0);
  // After a break the line must go high for at least one cycle
  localparam logic [CW-1:0] BREAK_GAP_LOAD = CW'((MIN_IDLE > 1) ? MIN_IDLE - 1 : 0);

  logic [2:0]           state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q, par_n;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic                 hold_inj;
  logic                 take;
  logic                 accept;
  logic                 launch;
  logic                 tx_n;

  assign in_ready = ~hold_full;
  assign accept   = in_valid && !hold_full;
  // A pending word may start straight away only when no break is requested
  assign launch   = hold_full && !break_req;

  // Next-state, counter and shift-register logic for the frame sequencer
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift_q;
    par_n   = par_q;
    take    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (break_req) begin
          state_n = ST_BREAK;
          cnt_n   = BREAK_LOAD;
        end else if (hold_full) begin
          take = 1'b1;
        end
      end
      ST_START: begin
        state_n = ST_DATA;
        cnt_n   = DATA_LOAD;
      end
      ST_DATA: begin
        if (cnt == '0) begin
          state_n = ST_PARITY;
        end else begin
          cnt_n   = cnt - CW'(1);
          shift_n = shift_q >> 1;
        end
      end
      ST_PARITY: state_n = ST_STOP;
      ST_STOP: begin
        if (MIN_IDLE > 0) begin
          state_n = ST_GAP;
          cnt_n   = GAP_LOAD;
        end else if (launch) begin
          take = 1'b1;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        // The last gap cycle doubles as the idle decision so that a kept-full
        // holding register gives a period of frame length plus MIN_IDLE
        if (cnt == '0) begin
          if (launch) take = 1'b1;
          else        state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ST_BREAK: begin
        if (cnt == '0) begin
          state_n = ST_GAP;
          cnt_n   = BREAK_GAP_LOAD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (take) begin
      state_n = ST_START;
      shift_n = hold_data;
      par_n   = (^hold_data) ^ hold_inj;
    end
  end

  // Line level for the state being entered, so tx comes straight from a flop
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_BREAK:  tx_n = 1'b0;
      ST_DATA:   tx_n = shift_n[0];
      ST_PARITY: tx_n = par_n;
      default:   tx_n = 1'b1;
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shift_q    <= shift_n;
      par_q      <= par_n;
      tx         <= tx_n;
      busy       <= (state_n != ST_IDLE);
      frame_done <= (state_n == ST_STOP);
    end
  end

  // One-entry holding register: filled on handshake, emptied when a frame starts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_inj  <= 1'b0;
    end else begin
      hold_full <= accept || (hold_full && !take);
      if (accept) begin
        hold_data <= in_data;
        hold_inj  <= parity_inject;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_parity_even.sv
// tb/tb_uart_tx_parity_even.sv - directed self-checking bench for uart_tx_parity_even
module tb_uart_tx_parity_even;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_valid, a_inj, a_break;
  logic [3:0] a_data;
  logic       a_ready, a_tx, a_busy, a_fd;
  logic       b_valid, b_inj, b_break;
  logic [3:0] b_data;
  logic       b_ready, b_tx, b_busy, b_fd;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx_parity_even #(.DATA_BITS(4), .MIN_IDLE(1), .BREAK_LEN(16)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(a_valid), .in_data(a_data),
    .parity_inject(a_inj), .in_ready(a_ready), .break_req(a_break),
    .tx(a_tx), .busy(a_busy), .frame_done(a_fd)
  );

  uart_tx_parity_even #(.DATA_BITS(4), .MIN_IDLE(0), .BREAK_LEN(16)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(b_valid), .in_data(b_data),
    .parity_inject(b_inj), .in_ready(b_ready), .break_req(b_break),
    .tx(b_tx), .busy(b_busy), .frame_done(b_fd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one word on dut a from idle and checks 9 cycles: frame, gap, idle
  task automatic send_a(input string tag, input logic [3:0] d, input logic inj,
                        input logic [31:0] exp_tx);
    logic [31:0] tv, fv, bv;
    tv = '0; fv = '0; bv = '0;
    @(negedge clk);
    a_valid = 1'b1; a_data = d; a_inj = inj;
    @(negedge clk);
    check({tag, "_ready_lo"}, a_ready, 0);
    a_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tv[i] = a_tx; fv[i] = a_fd; bv[i] = a_busy;
      if (i == 0) check({tag, "_ready_hi"}, a_ready, 1);
    end
    check({tag, "_tx"}, tv, exp_tx);
    check({tag, "_frame_done"}, fv, 32'h040);
    check({tag, "_busy"}, bv, 32'h0FF);
  endtask

  initial begin
    logic [31:0] tv, fv, bv, rv;
    logic        quiet;
    reset_n = 1'b1;
    a_valid = 0; a_inj = 0; a_break = 0; a_data = '0;
    b_valid = 0; b_inj = 0; b_break = 0; b_data = '0;

    // Asynchronous reset between clock edges
    #2 reset_n = 1'b0;
    #1;
    check("rst_tx", a_tx, 1);
    check("rst_ready", a_ready, 1);
    check("rst_busy", a_busy, 0);
    check("rst_frame_done", a_fd, 0);
    check("rst_b_tx", b_tx, 1);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Single frames on dut a
    send_a("f1011", 4'b1011, 1'b0, 32'h1F6);
    send_a("f3_inj", 4'h3, 1'b1, 32'h1E6);
    send_a("f3", 4'h3, 1'b0, 32'h1C6);

    // Back-to-back on dut b (no gap)
    tv = '0; fv = '0; rv = '0;
    @(negedge clk);
    b_valid = 1'b1; b_data = 4'h0;
    @(negedge clk);
    check("b2b_ready_lo", b_ready, 0);
    b_data = 4'hF;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      tv[i] = b_tx; fv[i] = b_fd; rv[i] = b_ready;
      if (i == 1) b_valid = 1'b0;
    end
    check("b2b_tx", tv, 32'h6F40);
    check("b2b_frame_done", fv, 32'h2040);
    check("b2b_ready", rv, 32'h7F81);
    check("b2b_idle_busy", b_busy, 0);

    // Break requested in idle with a word arriving on the same edge
    tv = '0; fv = '0; bv = '0;
    @(negedge clk);
    a_break = 1'b1; a_valid = 1'b1; a_data = 4'h5; a_inj = 1'b0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      tv[i] = a_tx; fv[i] = a_fd; bv[i] = a_busy;
      if (i == 0) begin
        check("brk_ready_lo", a_ready, 0);
        a_valid = 1'b0; a_break = 1'b0;
      end
    end
    check("brk_tx", tv, 32'h3950000);
    check("brk_frame_done", fv, 32'h800000);
    check("brk_busy", bv, 32'h1FFFFFF);

    // Break raised mid-frame: frame completes, then break
    tv = '0; fv = '0; bv = '0;
    @(negedge clk);
    a_valid = 1'b1; a_data = 4'h9;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      tv[i] = a_tx; fv[i] = a_fd; bv[i] = a_busy;
      if (i == 2) a_break = 1'b1;
      if (i == 9) a_break = 1'b0;
    end
    check("mbrk_tx", tv, 32'h60001D2);
    check("mbrk_frame_done", fv, 32'h40);
    check("mbrk_busy", bv, 32'h3FFFEFF);

    // Reset during DATA with a second word held
    @(negedge clk);
    a_valid = 1'b1; a_data = 4'h6;
    @(negedge clk);
    a_data = 4'hC;
    @(negedge clk);
    check("mrst_start_tx", a_tx, 0);
    @(negedge clk);
    check("mrst_d0_tx", a_tx, 0);
    check("mrst_hold_full", a_ready, 0);
    a_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mrst_tx", a_tx, 1);
    check("mrst_ready", a_ready, 1);
    check("mrst_busy", a_busy, 0);
    check("mrst_frame_done", a_fd, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_tx !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b1) quiet = 1'b0;
    end
    check("mrst_no_resume", quiet, 1);
    send_a("fA", 4'hA, 1'b0, 32'h1D4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_parity_even.md
# uart_tx_parity_even

- Serial transmitter with even parity.
- Upstream neighbour of the receive-side even-parity frame checker: drives the one-bit serial line that the checker samples once per clock.
- Frames are built from parallel words accepted on a valid/ready handshake. A one-entry holding register lets frames go out back-to-back.
- Line breaks are generated on request, so the checker's break/idle recovery path can be exercised.

## Interface
- DATA_BITS, 4, data bits per frame (LSB first).
- MIN_IDLE, 1, high-level gap cycles inserted after each stop bit (0 allowed).
- BREAK_LEN, 16, cycles the line is held low for a break (≥2).

- clk  in  1  single clock, all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  word offered.
- in_data  in  DATA_BITS  word to transmit.
- parity_inject  in  1  sampled with in_data; when 1, that frame's parity bit is inverted (error injection).
- in_ready  out  1  holding register empty; transfer occurs when in_valid && in_ready at a rising edge.
- break_req  in  1  level request for a line break.
- tx  out  1  serial line, registered, idle high.
- busy  out  1  FSM not in IDLE.
- frame_done  out  1  one-cycle pulse during the stop-bit cycle.

## Operation
- Reset (asynchronous, while reset_n=0):
  - tx=1, in_ready=1, busy=0, frame_done=0.
  - Holding register empty; FSM in IDLE.
- Frame on tx, one bit per clock:
  - start (0);
  - d0..d(DATA_BITS-1);
  - parity = XOR(data) ^ inject;
  - stop (1).
- Total ones over data plus parity is even unless inject=1.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP, BREAK.
- IDLE (tx=1):
  - If break_req=1, go to BREAK. Break has priority over pending data.
  - Else if holding full, go to START, moving holding into the shift register and freeing holding.
- START → DATA.
- DATA shifts LSB first for DATA_BITS cycles → PARITY.
- PARITY → STOP.
- STOP (tx=1, frame_done=1):
  - MIN_IDLE>0: go to GAP.
  - MIN_IDLE=0: if holding full and break_req=0, go directly to START (no high gap beyond the stop bit); otherwise go to IDLE.
- GAP (tx=1) counts MIN_IDLE cycles → IDLE.
- BREAK (tx=0) lasts BREAK_LEN cycles, then GAP for max(MIN_IDLE,1) cycles, so the downstream checker sees at least one high bit before any start bit.
- break_req asserted mid-frame is not acted on until the FSM next evaluates it (IDLE, or STOP when MIN_IDLE=0). The frame in flight always completes.
- A word pending in holding during BREAK is retained and sent after the gap.
- Holding accepts a new word in any state, including during a frame, provided it is empty.
- A load into the shift register and a new acceptance may occur on the same edge.
- Reset asserted mid-frame aborts immediately: tx=1 asynchronously and any pending word is discarded. No partial frame resumes.

## Timing
- Transfer at edge E0 fills holding; in_ready=0 after E0.
- If the FSM is in IDLE, edge E1 enters START: tx=0 from E1.
- in_ready returns to 1 after E1.
- Frame length is DATA_BITS+3 cycles (7 at default).
- Frame period is DATA_BITS+3+MIN_IDLE cycles when holding is kept full.
- frame_done is high exactly for the stop-bit cycle.
- busy is high from entering START/BREAK until returning to IDLE.
- in_ready is a registered function of holding state; there is no combinational path from in_valid.

## Test plan
- Reset: drive reset_n=0 mid-cycle → tx=1, in_ready=1, busy=0, frame_done=0 without waiting for a clock edge.
- Single frame: in_data=4'b1011, inject=0 → tx 0,1,1,0,1,1,1 on consecutive cycles after the start edge; frame_done on the 7th cycle; then tx=1 for the gap.
- Back-to-back with MIN_IDLE=0: send 4'h0 then 4'hF, in_valid held → tx 0,0,0,0,0,0,1,0,1,1,1,1,0,1 (14 cycles) with no gap; in_ready=0 while the second word waits.
- Parity injection: in_data=4'h3 with inject=1 → parity bit 1 instead of 0; downstream checker flags error.
- Break: break_req=1 in IDLE with a word pending → tx=0 for 16 cycles, then ≥1 cycle of 1, then the pending frame; break_req raised mid-frame → current frame completes unaltered first.
- Reset mid-DATA with a word in holding → tx=1 at once; after release in_ready=1, busy=0, and no frame is emitted until new data arrives.
